// File: rtl/ts_scroller.sv
// Text-screen scroll engine: on each scroll request, copies rows 1..ROWS-1 up by one
// row and fills the last row with blank_cell. Up to three extra requests are queued.
module ts_scroller #(
  parameter int COLUMNS    = 80,
  parameter int ROWS       = 51,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scroll,
  input  logic [DATA_WIDTH-1:0] blank_cell,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST_SRC = ADDR_WIDTH'(COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] LAST_COPY = ADDR_WIDTH'((ROWS-1)*COLUMNS-1);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(ROWS*COLUMNS-1);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] src, src_nx, dst, dst_nx;
  logic [DATA_WIDTH-1:0] data, data_nx;
  logic [1:0]            pending, pending_nx;
  logic                  done_q, finish;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      src     <= '0;
      dst     <= '0;
      data    <= '0;
      pending <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      src     <= src_nx;
      dst     <= dst_nx;
      data    <= data_nx;
      pending <= pending_nx;
      done_q  <= finish;
    end
  end

  always_comb begin
    state_nx   = state;
    src_nx     = src;
    dst_nx     = dst;
    data_nx    = data;
    pending_nx = pending;
    finish     = 1'b0;
    case (state)
      IDLE: if (scroll) begin
        state_nx = READ;
        src_nx   = FIRST_SRC;
        dst_nx   = '0;
      end
      READ: if (mem_ready) begin
        data_nx  = mem_rdata;
        state_nx = WRITE;
      end
      WRITE: if (mem_ready) begin
        src_nx   = src + 1'b1;
        dst_nx   = dst + 1'b1;
        state_nx = (dst == LAST_COPY) ? CLEAR : READ;
      end
      CLEAR: if (mem_ready) begin
        dst_nx = dst + 1'b1;
        finish = (dst == LAST_CELL);
      end
      default: state_nx = IDLE;
    endcase

    // A new request arriving with one already queued nets out to no change.
    if (finish) begin
      src_nx = FIRST_SRC;
      dst_nx = '0;
      if (pending != 2'd0) begin
        state_nx   = READ;
        pending_nx = scroll ? pending : pending - 2'd1;
      end else begin
        state_nx = scroll ? READ : IDLE;
      end
    end else if (state != IDLE && scroll && pending != 2'd3) begin
      pending_nx = pending + 2'd1;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign mem_read  = (state == READ);
  assign mem_write = (state == WRITE) || (state == CLEAR);
  assign mem_addr  = (state == READ) ? src : mem_write ? dst : '0;
  assign mem_wdata = (state == CLEAR) ? blank_cell : data;
endmodule
